acc_addsub_stage: RTL and testbench



---
 rtl/acc_addsub_stage_pkg.sv | 16 +
 rtl/acc_addsub_stage_addsub_core.sv | 38 +++
 rtl/acc_addsub_stage.sv | 140 ++++++++++++++
 tb/tb_acc_addsub_stage.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_addsub_stage_pkg.sv
// Shared types and constants for the accumulating add/subtract stage.
package acc_addsub_stage_pkg;

    // Command handshake phases: wait for a command, update the accumulator,
    // then present the result until the consumer takes it.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Meaning of in_mode / the adder's sub input.
    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage : acc_addsub_stage_pkg

// File: rtl/acc_addsub_stage_addsub_core.sv
// Combinational two's-complement adder/subtractor.
// Subtraction is done as a + ~b + 1, so cout = 1 means "no borrow".
// The MSB is added separately so the carry into it is visible for the
// signed-overflow flag. WIDTH must be at least 2.
module addsub_core
    import acc_addsub_stage_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] low_sum;   // lower WIDTH-1 bits plus carry into the MSB
    logic             carry_msb_in;
    logic [1:0]       msb_sum;   // MSB result bit plus carry out of the MSB

    // Ripple the lower bits, then the MSB, exposing both carries.
    always_comb begin
        // NOTE: every output is assigned on every pass through this block, so
        // no path can leave a value unassigned and infer a latch.
        b_eff        = (sub == MODE_SUB) ? ~b : b;
        low_sum      = {1'b0, a[WIDTH-2:0]} + {1'b0, b_eff[WIDTH-2:0]}
                     + {{(WIDTH-1){1'b0}}, sub};
        carry_msb_in = low_sum[WIDTH-1];
        msb_sum      = {1'b0, a[WIDTH-1]} + {1'b0, b_eff[WIDTH-1]}
                     + {1'b0, carry_msb_in};
        sum          = {msb_sum[0], low_sum[WIDTH-2:0]};
        cout         = msb_sum[1];
        ovf          = carry_msb_in ^ msb_sum[1];
    end

endmodule : addsub_core

// File: rtl/acc_addsub_stage.sv
// Accumulating add/subtract stage with a valid/ready command port and a
// valid/ready result port. One command is in flight at a time: it is
// captured in IDLE, applied to the accumulator in EXEC, and the result is
// held in RESP until out_ready. All state lives here; the adder is pure logic.
module acc_addsub_stage
    import acc_addsub_stage_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    input  logic             in_load,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_acc,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             ovf_sticky
);

    state_e           state_q;

    // Captured command, so the inputs may change while it executes.
    logic [WIDTH-1:0] b_q;
    logic             mode_q;
    logic             load_q;

    // Architectural state and registered handshake outputs.
    logic [WIDTH-1:0] acc_q;
    logic             cout_q;
    logic             ovf_q;
    logic             sticky_q;
    logic             out_valid_q;
    logic             in_ready_q;

    // Adder result: the next accumulator/flag values for an arithmetic op.
    logic [WIDTH-1:0] sum_d;
    logic             cout_d;
    logic             ovf_d;

    addsub_core #(
        .WIDTH (WIDTH)
    ) u_addsub_core (
        .a    (acc_q),
        .b    (b_q),
        .sub  (mode_q),
        .sum  (sum_d),
        .cout (cout_d),
        .ovf  (ovf_d)
    );

    // Command FSM plus accumulator/flag and handshake registers.
    always_ff @(posedge clk) begin
        // NOTE: state is written with non-blocking assignments so every
        // register samples values from before the edge, independent of
        // statement order inside this block.
        if (rst) begin
            // NOTE: the captured-command registers are reset along with the
            // rest; it keeps the whole register set in one uniform branch and
            // they are never read before a new capture anyway.
            state_q     <= ST_IDLE;
            b_q         <= '0;
            mode_q      <= MODE_ADD;
            load_q      <= 1'b0;
            acc_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            sticky_q    <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        b_q        <= in_data;
                        mode_q     <= in_mode;
                        load_q     <= in_load;
                        in_ready_q <= 1'b0;
                        state_q    <= ST_EXEC;
                    end
                end

                ST_EXEC: begin
                    if (load_q) begin
                        acc_q    <= b_q;
                        cout_q   <= 1'b0;
                        ovf_q    <= 1'b0;
                        sticky_q <= 1'b0;
                    end else begin
                        acc_q    <= sum_d;
                        cout_q   <= cout_d;
                        ovf_q    <= ovf_d;
                        sticky_q <= sticky_q | ovf_d;
                    end
                    out_valid_q <= 1'b1;
                    state_q     <= ST_RESP;
                end

                ST_RESP: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end

                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_acc    = acc_q;
    assign out_cout   = cout_q;
    assign out_ovf    = ovf_q;
    assign ovf_sticky = sticky_q;

    // The two handshake sides are never open at the same time.
    a_ready_valid_exclusive : assert property (
        @(posedge clk) disable iff (rst) !(in_ready_q && out_valid_q)
    );

    // in_ready tracks IDLE and out_valid tracks RESP exactly.
    a_ready_matches_idle : assert property (
        @(posedge clk) disable iff (rst) in_ready_q == (state_q == ST_IDLE)
    );
    a_valid_matches_resp : assert property (
        @(posedge clk) disable iff (rst) out_valid_q == (state_q == ST_RESP)
    );

endmodule : acc_addsub_stage

// File: tb/tb_acc_addsub_stage.sv
// Self-checking bench for acc_addsub_stage. Expected results come from a
// behavioural model using integer arithmetic on the two's-complement values.
module tb_acc_addsub_stage;
    import acc_addsub_stage_pkg::*;

    localparam int W    = 4;
    localparam int MASK = (1 << W) - 1;
    localparam int SMAX = (1 << (W - 1)) - 1;
    localparam int SMIN = -(1 << (W - 1));

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         in_mode;
    logic         in_load;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_acc;
    logic         out_cout;
    logic         out_ovf;
    logic         ovf_sticky;

    int tests_run = 0;
    int failed    = 0;

    // Reference model state.
    logic [W-1:0] m_acc;
    logic         m_cout;
    logic         m_ovf;
    logic         m_sticky;

    acc_addsub_stage #(
        .WIDTH (W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_mode    (in_mode),
        .in_load    (in_load),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_acc    (out_acc),
        .out_cout   (out_cout),
        .out_ovf    (out_ovf),
        .ovf_sticky (ovf_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int sx(input int v);
        return (v > SMAX) ? v - (1 << W) : v;
    endfunction

    task automatic model_reset();
        m_acc = '0; m_cout = 1'b0; m_ovf = 1'b0; m_sticky = 1'b0;
    endtask

    task automatic model_step(input logic ld, input logic md, input logic [W-1:0] b);
        int a_u, b_u, u, r;
        if (ld) begin
            m_acc = b; m_cout = 1'b0; m_ovf = 1'b0; m_sticky = 1'b0;
        end else begin
            a_u = int'(m_acc);
            b_u = int'(b);
            u   = md ? a_u + (MASK - b_u) + 1 : a_u + b_u;
            r   = md ? sx(a_u) - sx(b_u) : sx(a_u) + sx(b_u);
            m_cout   = u[W];
            m_ovf    = (r > SMAX) || (r < SMIN);
            m_acc    = u[W-1:0];
            m_sticky = m_sticky | m_ovf;
        end
    endtask

    function automatic logic [W+2:0] model_vec();
        return {m_acc, m_cout, m_ovf, m_sticky};
    endfunction

    function automatic logic [W+2:0] dut_vec();
        return {out_acc, out_cout, out_ovf, ovf_sticky};
    endfunction

    // Issue one command, check the 2-edge latency, hold the result for
    // `hold` cycles (with a stray in_valid pulse), then release it.
    task automatic do_cmd(input logic ld, input logic md, input logic [W-1:0] b,
                          input int hold, input string tag);
        tests_run++;
        if (in_ready !== 1'b1) begin
            failed++;
            $display("FAIL %s_ready: in_ready=%b expected 1", tag, in_ready);
        end
        in_valid = 1'b1; in_load = ld; in_mode = md; in_data = b;
        @(posedge clk); #1;
        // Scramble the inputs: the stage must work from its captured copy.
        in_valid = 1'b0; in_load = 1'($urandom); in_mode = 1'($urandom);
        in_data = W'($urandom);
        tests_run++;
        if ({out_valid, in_ready} !== 2'b00) begin
            failed++;
            $display("FAIL %s_exec: valid/ready=%b%b expected 00", tag, out_valid, in_ready);
        end
        @(posedge clk); #1;
        model_step(ld, md, b);
        tests_run++;
        if (out_valid !== 1'b1) begin
            failed++;
            $display("FAIL %s_latency: out_valid=%b expected 1", tag, out_valid);
        end
        tests_run++;
        if (dut_vec() !== model_vec()) begin
            failed++;
            $display("FAIL %s_result: acc/cout/ovf/sticky=%h expected %h", tag, dut_vec(), model_vec());
        end
        for (int i = 0; i < hold; i++) begin
            out_ready = 1'b0;
            if (i == 0) begin
                in_valid = 1'b1; in_load = 1'b1; in_data = W'($urandom);
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
            tests_run++;
            if ({out_valid, in_ready, dut_vec()} !== {2'b10, model_vec()}) begin
                failed++;
                $display("FAIL %s_hold%0d: valid/ready/outs=%b%b/%h expected 10/%h",
                         tag, i, out_valid, in_ready, dut_vec(), model_vec());
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        tests_run++;
        if ({out_valid, in_ready, dut_vec()} !== {2'b01, model_vec()}) begin
            failed++;
            $display("FAIL %s_release: valid/ready/outs=%b%b/%h expected 01/%h",
                     tag, out_valid, in_ready, dut_vec(), model_vec());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_load = 1'b1;
        in_mode = MODE_ADD; in_data = 4'h9;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        tests_run++;
        if ({out_valid, in_ready, dut_vec()} !== {2'b01, model_vec()}) begin
            failed++;
            $display("FAIL reset_state: valid/ready/outs=%b%b/%h expected 01/%h",
                     out_valid, in_ready, dut_vec(), model_vec());
        end
        in_valid = 1'b0; out_ready = 1'b0; rst = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if ({out_valid, in_ready, out_acc} !== {2'b01, W'(0)}) begin
            failed++;
            $display("FAIL reset_release: valid/ready/acc=%b%b/%h expected 01/0",
                     out_valid, in_ready, out_acc);
        end
    endtask

    // Directed arithmetic cases with hand-computed results.
    typedef struct {
        logic         ld;
        logic         md;
        logic [W-1:0] b;
        logic [W+2:0] exp;
    } dir_t;

    task automatic test_directed();
        dir_t tbl[12];
        tbl[0]  = '{1'b1, MODE_ADD, 4'h2, {4'h2, 3'b000}};
        tbl[1]  = '{1'b0, MODE_ADD, 4'h1, {4'h3, 3'b000}};
        tbl[2]  = '{1'b1, MODE_ADD, 4'h5, {4'h5, 3'b000}};
        tbl[3]  = '{1'b0, MODE_SUB, 4'h1, {4'h4, 3'b100}};
        tbl[4]  = '{1'b1, MODE_SUB, 4'h0, {4'h0, 3'b000}};
        tbl[5]  = '{1'b0, MODE_SUB, 4'h1, {4'hF, 3'b000}};
        tbl[6]  = '{1'b1, MODE_ADD, 4'h7, {4'h7, 3'b000}};
        tbl[7]  = '{1'b0, MODE_ADD, 4'h1, {4'h8, 3'b011}};
        tbl[8]  = '{1'b0, MODE_ADD, 4'h1, {4'h9, 3'b001}};
        tbl[9]  = '{1'b1, MODE_ADD, 4'h0, {4'h0, 3'b000}};
        tbl[10] = '{1'b1, MODE_ADD, 4'hF, {4'hF, 3'b000}};
        tbl[11] = '{1'b0, MODE_ADD, 4'h1, {4'h0, 3'b100}};
        for (int i = 0; i < 12; i++) begin
            do_cmd(tbl[i].ld, tbl[i].md, tbl[i].b, 0, $sformatf("dir%0d", i));
            tests_run++;
            if (dut_vec() !== tbl[i].exp) begin
                failed++;
                $display("FAIL dir%0d_const: acc/cout/ovf/sticky=%h expected %h",
                         i, dut_vec(), tbl[i].exp);
            end
        end
    endtask

    task automatic test_hold();
        do_cmd(1'b1, MODE_ADD, 4'h3, 0, "hold_load");
        do_cmd(1'b0, MODE_SUB, 4'h5, 3, "hold");
        // The in_valid pulse during RESP must not have been queued.
        repeat (2) begin
            @(posedge clk); #1;
            tests_run++;
            if ({out_valid, in_ready, dut_vec()} !== {2'b01, model_vec()}) begin
                failed++;
                $display("FAIL hold_noqueue: valid/ready/outs=%b%b/%h expected 01/%h",
                         out_valid, in_ready, dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_reset_exec();
        do_cmd(1'b1, MODE_ADD, 4'h5, 0, "rexec_load");
        do_cmd(1'b0, MODE_ADD, 4'h6, 0, "rexec_ovf");
        in_valid = 1'b1; in_load = 1'b0; in_mode = MODE_ADD; in_data = 4'h3;
        @(posedge clk); #1;
        in_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        tests_run++;
        if ({out_valid, in_ready, dut_vec()} !== {2'b01, model_vec()}) begin
            failed++;
            $display("FAIL rexec_state: valid/ready/outs=%b%b/%h expected 01/%h",
                     out_valid, in_ready, dut_vec(), model_vec());
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            tests_run++;
            if ({out_valid, in_ready, dut_vec()} !== {2'b01, model_vec()}) begin
                failed++;
                $display("FAIL rexec_after%0d: valid/ready/outs=%b%b/%h expected 01/%h",
                         i, out_valid, in_ready, dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_back_to_back();
        int seen;
        do_cmd(1'b1, MODE_ADD, 4'h1, 0, "b2b_load");
        in_valid = 1'b1; in_load = 1'b0; in_mode = MODE_ADD; in_data = 4'h1;
        out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen++;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        repeat (4) model_step(1'b0, MODE_ADD, 4'h1);
        tests_run++;
        if (seen != 4) begin
            failed++;
            $display("FAIL b2b_count: results=%0d expected 4", seen);
        end
        tests_run++;
        if ({in_ready, dut_vec()} !== {1'b1, model_vec()}) begin
            failed++;
            $display("FAIL b2b_final: ready/outs=%b/%h expected 1/%h",
                     in_ready, dut_vec(), model_vec());
        end
    endtask

    task automatic test_random();
        logic ld;
        do_cmd(1'b1, MODE_ADD, W'($urandom), 0, "rnd_first");
        for (int i = 0; i < 40; i++) begin
            ld = ($urandom_range(0, 3) == 0);
            do_cmd(ld, 1'($urandom), W'($urandom), $urandom_range(0, 2),
                   $sformatf("rnd%0d", i));
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_mode = MODE_ADD;
        in_load = 1'b0; out_ready = 1'b0;
        model_reset();
        test_reset();
        test_directed();
        test_hold();
        test_reset_exec();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule : tb_acc_addsub_stage
